// File: rtl/bcd_counter_n.sv
// bcd_counter_n
//   Multi-digit BCD up/down counter for the timer datapath. DIGITS decade
//   stages are chained with a combinational borrow/carry, so a full
//   multi-digit step resolves within one clock.
//
//   Optional feature: define BCD_CNT_AUTORELOAD_EN to add a reload register.
//   The register captures the sanitised load value. With WRAP=1, a terminal
//   event restores count from the reload register instead of wrapping to
//   all 9s or all 0s.
//
// Parameters
//   DIGITS : number of BCD decades (1..8)
//   WRAP   : 1 = wrap at terminal value, 0 = hold at terminal value
//
// Ports
//   clk    in   sole clock, rising edge
//   clear  in   synchronous active-high reset, highest priority
//   load   in   parallel load of `in` (nibbles > 9 forced to 9)
//   en     in   count enable
//   up_dn  in   1 = count up, 0 = count down
//   in     in   BCD load value, digit 0 in in[3:0]
//   count  out  registered BCD count
//   zero   out  combinational, count is all zeros
//   tc     out  combinational, en & count at terminal for current direction
//   done   out  registered sticky terminal-event flag
module bcd_counter_n #(
  parameter int DIGITS = 2,
  parameter int WRAP   = 1
) (
  input  logic                  clk,
  input  logic                  clear,
  input  logic                  load,
  input  logic                  en,
  input  logic                  up_dn,
  input  logic [4*DIGITS-1:0]   in,
  output logic [4*DIGITS-1:0]   count,
  output logic                  zero,
  output logic                  tc,
  output logic                  done
);

  localparam int W = 4 * DIGITS;

  // Force any non-BCD nibble to 9 so a digit never exceeds 9.
  function automatic logic [W-1:0] sanitise(input logic [W-1:0] v);
    logic [W-1:0] r;
    for (int k = 0; k < DIGITS; k++) begin
      r[4*k +: 4] = (v[4*k +: 4] > 4'd9) ? 4'd9 : v[4*k +: 4];
    end
    return r;
  endfunction

  function automatic logic [W-1:0] all_nines(input int unused_dummy);
    logic [W-1:0] r;
    r = '0;
    if (unused_dummy == 0) begin
      for (int k = 0; k < DIGITS; k++) r[4*k +: 4] = 4'd9;
    end
    return r;
  endfunction

  // One decimal step across all digits. The carry/borrow enters digit 0
  // and stops at the first digit that does not roll over.
  function automatic logic [W-1:0] bcd_step(input logic [W-1:0] v, input logic up);
    logic [W-1:0] r;
    logic         c;
    r = v;
    c = 1'b1;
    for (int k = 0; k < DIGITS; k++) begin
      if (c) begin
        if (up) begin
          if (v[4*k +: 4] == 4'd9) begin
            r[4*k +: 4] = 4'd0;
          end else begin
            r[4*k +: 4] = v[4*k +: 4] + 4'd1;
            c = 1'b0;
          end
        end else begin
          if (v[4*k +: 4] == 4'd0) begin
            r[4*k +: 4] = 4'd9;
          end else begin
            r[4*k +: 4] = v[4*k +: 4] - 4'd1;
            c = 1'b0;
          end
        end
      end
    end
    return r;
  endfunction

  localparam logic [W-1:0] NINES = all_nines(0);

  logic [W-1:0] count_q, count_d;
  logic         done_q, done_d;
  logic         at_term;
  logic [W-1:0] wrap_val;

`ifdef BCD_CNT_AUTORELOAD_EN
  logic [W-1:0] reload_q, reload_d;
  assign wrap_val = reload_q;
`else
  assign wrap_val = up_dn ? '0 : NINES;
`endif

  assign at_term = up_dn ? (count_q == NINES) : (count_q == '0);

  always_comb begin
    count_d = count_q;
    done_d  = done_q;
`ifdef BCD_CNT_AUTORELOAD_EN
    reload_d = reload_q;
`endif
    if (load) begin
      count_d = sanitise(in);
      done_d  = 1'b0;
`ifdef BCD_CNT_AUTORELOAD_EN
      reload_d = sanitise(in);
`endif
    end else if (en) begin
      if (at_term) begin
        done_d = 1'b1;
        // WRAP=0 leaves count at the terminal value, keeping tc asserted.
        if (WRAP != 0) count_d = wrap_val;
      end else begin
        count_d = bcd_step(count_q, up_dn);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      count_q <= '0;
      done_q  <= 1'b0;
`ifdef BCD_CNT_AUTORELOAD_EN
      reload_q <= '0;
`endif
    end else begin
      count_q <= count_d;
      done_q  <= done_d;
`ifdef BCD_CNT_AUTORELOAD_EN
      reload_q <= reload_d;
`endif
    end
  end

  assign count = count_q;
  assign done  = done_q;
  assign zero  = (count_q == '0);
  assign tc    = en & at_term;

endmodule

// File: tb/tb_bcd_counter_n.sv
module tb_bcd_counter_n;

  logic       clk = 1'b0;
  logic       clear, load, en, up_dn;
  logic [7:0] in;
  logic [7:0] w_count, s_count;
  logic       w_zero, w_tc, w_done;
  logic       s_zero, s_tc, s_done;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // Wrapping counter
  bcd_counter_n #(.DIGITS(2), .WRAP(1)) u_wrap (
    .clk(clk), .clear(clear), .load(load), .en(en), .up_dn(up_dn), .in(in),
    .count(w_count), .zero(w_zero), .tc(w_tc), .done(w_done)
  );

  // Saturating counter sharing the same stimulus
  bcd_counter_n #(.DIGITS(2), .WRAP(0)) u_sat (
    .clk(clk), .clear(clear), .load(load), .en(en), .up_dn(up_dn), .in(in),
    .count(s_count), .zero(s_zero), .tc(s_tc), .done(s_done)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    clear = 1'b1; load = 1'b0; en = 1'b0; up_dn = 1'b0; in = 8'h00;
    tick();
    clear = 1'b0;
    #1;
    check("rst_count", w_count, 8'h00);
    check("rst_done", w_done, 1'b0);
    check("rst_zero", w_zero, 1'b1);
    check("rst_tc_en0", w_tc, 1'b0);
    en = 1'b1;
    #1;
    check("rst_tc_en1_down", w_tc, 1'b1);
    up_dn = 1'b1;
    #1;
    check("rst_tc_en1_up", w_tc, 1'b0);
    up_dn = 1'b0;

    // Down-count wrap from 00
    tick();
    check("wrap_e1", w_count, 8'h99);
    check("wrap_done", w_done, 1'b1);
    check("sat_down_hold", s_count, 8'h00);
    check("sat_down_done", s_done, 1'b1);
    tick();
    check("wrap_e2", w_count, 8'h98);
    tick();
    check("wrap_e3", w_count, 8'h97);
    check("wrap_done_sticky", w_done, 1'b1);
    en = 1'b0;

    // Borrow and carry
    in = 8'h10; load = 1'b1;
    tick();
    load = 1'b0;
    check("load10", w_count, 8'h10);
    check("load_clr_done", w_done, 1'b0);
    en = 1'b1; up_dn = 1'b0;
    tick();
    check("borrow", w_count, 8'h09);
    check("borrow_zero", w_zero, 1'b0);
    up_dn = 1'b1;
    tick();
    check("carry", w_count, 8'h10);
    tick();
    check("up11", w_count, 8'h11);
    en = 1'b0;

    // Saturate up (u_sat) and wrap up (u_wrap)
    in = 8'h98; load = 1'b1; up_dn = 1'b1;
    tick();
    load = 1'b0;
    en = 1'b1;
    #1;
    check("sat_tc_98", s_tc, 1'b0);
    tick();
    check("sat_e1", s_count, 8'h99);
    check("sat_e1_done", s_done, 1'b0);
    check("sat_e1_tc", s_tc, 1'b1);
    tick();
    check("sat_e2", s_count, 8'h99);
    check("sat_e2_done", s_done, 1'b1);
    check("sat_e2_tc", s_tc, 1'b1);
    check("wrap_up_00", w_count, 8'h00);
    check("wrap_up_done", w_done, 1'b1);
    tick();
    check("sat_e3", s_count, 8'h99);
    check("wrap_up_01", w_count, 8'h01);

    // Priority and sanitise: load beats en, done cleared
    load = 1'b1; in = 8'h5C;
    tick();
    check("sanitise", w_count, 8'h59);
    check("sanitise_done", w_done, 1'b0);
    check("sanitise_sat", s_count, 8'h59);

    // Load with en at terminal: tc high that cycle, load wins, done stays 0
    in = 8'h99; en = 1'b0;
    tick();
    en = 1'b1; in = 8'h25;
    #1;
    check("ld_term_tc", w_tc, 1'b1);
    tick();
    check("ld_term_count", w_count, 8'h25);
    check("ld_term_done", w_done, 1'b0);

    // Clear beats load
    clear = 1'b1; in = 8'h77;
    tick();
    clear = 1'b0; load = 1'b0; en = 1'b0;
    check("clr_vs_load", w_count, 8'h00);

    // Mid-count clear
    in = 8'h47; load = 1'b1; up_dn = 1'b0;
    tick();
    load = 1'b0; en = 1'b1;
    tick();
    check("mid_e1", w_count, 8'h46);
    tick();
    check("mid_e2", w_count, 8'h45);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("mid_clr", w_count, 8'h00);
    check("mid_clr_done", w_done, 1'b0);
    en = 1'b0;

    // Terminal wrap from a loaded value (reload when compiled in)
    in = 8'h03; load = 1'b1;
    tick();
    load = 1'b0; en = 1'b1;
    tick();
    check("rl_e1", w_count, 8'h02);
    tick();
    check("rl_e2", w_count, 8'h01);
    tick();
    check("rl_e3", w_count, 8'h00);
    check("rl_e3_done", w_done, 1'b0);
    tick();
`ifdef BCD_CNT_AUTORELOAD_EN
    check("rl_e4", w_count, 8'h03);
`else
    check("rl_e4", w_count, 8'h99);
`endif
    check("rl_e4_done", w_done, 1'b1);
    tick();
`ifdef BCD_CNT_AUTORELOAD_EN
    check("rl_e5", w_count, 8'h02);
`else
    check("rl_e5", w_count, 8'h98);
`endif
    en = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
